// File: rtl/pipe_ctrl_unit.sv
// Control unit for the 5-stage MIPS pipeline: ID decode, control carried through
// ID/EX, EX/MEM and MEM/WB, load-use / RAW stalls, forwarding selects and flushes.
module pipe_ctrl_unit #(
    parameter int RA_W   = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr_id,
    input  logic            zero_ex,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            ifid_flush,
    output logic            pc_src_ex,
    output logic            jump_id,
    output logic            reg_dst_ex,
    output logic            alu_src_ex,
    output logic [2:0]      alu_op_ex,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            mem_write_mem,
    output logic            reg_write_wb,
    output logic            mem_to_reg_wb,
    output logic [RA_W-1:0] dest_wb
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_J = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2a;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic       ne;
        logic       reg_dst;
        logic       alu_src;
        logic [2:0] alu_op;
    } ctrl_t;

    ctrl_t           dec_id, idex_d, idex_q;
    logic            is_j_id, uses_rt_id;
    logic [RA_W-1:0] rs_id, rt_id, rd_id;
    logic [RA_W-1:0] rs_ex_d, rs_ex_q, rt_ex_d, rt_ex_q, dest_ex_d, dest_ex_q;
    logic            exmem_reg_write_d, exmem_reg_write_q, exmem_mem_to_reg_d, exmem_mem_to_reg_q;
    logic            exmem_mem_write_d, exmem_mem_write_q;
    logic [RA_W-1:0] dest_mem_d, dest_mem_q, dest_wb_d, dest_wb_q;
    logic            memwb_reg_write_d, memwb_reg_write_q, memwb_mem_to_reg_d, memwb_mem_to_reg_q;
    logic            hit_ex, hit_mem, load_use, raw_stall, stall, take;
    logic            unused_instr;

    assign rs_id        = instr_id[21 +: RA_W];
    assign rt_id        = instr_id[16 +: RA_W];
    assign rd_id        = instr_id[11 +: RA_W];
    assign unused_instr = ^instr_id;

    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src,
                                           input logic rw_mem, input logic [RA_W-1:0] d_mem,
                                           input logic rw_wb,  input logic [RA_W-1:0] d_wb);
        if (src != '0 && rw_mem && d_mem == src) return 2'b10;
        if (src != '0 && rw_wb && d_wb == src)   return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        dec_id     = '0;
        is_j_id    = 1'b0;
        uses_rt_id = 1'b0;
        case (instr_id[31:26])
            OP_RTYPE: begin
                uses_rt_id       = 1'b1;
                dec_id.reg_write = 1'b1;
                dec_id.reg_dst   = 1'b1;
                case (instr_id[5:0])
                    FN_ADD:  dec_id.alu_op = 3'b010;
                    FN_SUB:  dec_id.alu_op = 3'b110;
                    FN_AND:  dec_id.alu_op = 3'b000;
                    FN_OR:   dec_id.alu_op = 3'b001;
                    FN_SLT:  dec_id.alu_op = 3'b111;
                    default: dec_id = '0;
                endcase
            end
            OP_LW: begin
                dec_id.reg_write  = 1'b1;
                dec_id.alu_src    = 1'b1;
                dec_id.mem_to_reg = 1'b1;
                dec_id.alu_op     = 3'b010;
            end
            OP_SW: begin
                uses_rt_id       = 1'b1;
                dec_id.alu_src   = 1'b1;
                dec_id.mem_write = 1'b1;
                dec_id.alu_op    = 3'b010;
            end
            OP_ADDI: begin
                dec_id.reg_write = 1'b1;
                dec_id.alu_src   = 1'b1;
                dec_id.alu_op    = 3'b010;
            end
            OP_BEQ, OP_BNE: begin
                uses_rt_id    = 1'b1;
                dec_id.branch = 1'b1;
                dec_id.ne     = (instr_id[31:26] == OP_BNE);
                dec_id.alu_op = 3'b110;
            end
            OP_J:    is_j_id = 1'b1;
            default: ;
        endcase
    end

    // Hazard detection: register $0 is never a real producer.
    always_comb begin
        hit_ex    = (dest_ex_q != '0) && ((dest_ex_q == rs_id) || (uses_rt_id && dest_ex_q == rt_id));
        hit_mem   = (dest_mem_q != '0) && ((dest_mem_q == rs_id) || (uses_rt_id && dest_mem_q == rt_id));
        load_use  = idex_q.mem_to_reg && hit_ex;
        raw_stall = !FWD_EN && ((idex_q.reg_write && hit_ex) || (exmem_reg_write_q && hit_mem));
        take      = idex_q.branch && (zero_ex ^ idex_q.ne);
        stall     = (load_use || raw_stall) && !take;
    end

    assign pc_src_ex  = take;
    assign pc_write   = !stall;
    assign ifid_write = !stall;
    assign jump_id    = is_j_id && !take && !stall;
    assign ifid_flush = take || jump_id;

    always_comb begin
        idex_d    = dec_id;
        rs_ex_d   = rs_id;
        rt_ex_d   = rt_id;
        dest_ex_d = dec_id.reg_dst ? rd_id : rt_id;
        // A squashed, stalled or jump instruction leaves nothing behind in EX.
        if (take || stall || is_j_id) begin
            idex_d    = '0;
            rs_ex_d   = '0;
            rt_ex_d   = '0;
            dest_ex_d = '0;
        end
        exmem_reg_write_d  = idex_q.reg_write;
        exmem_mem_to_reg_d = idex_q.mem_to_reg;
        exmem_mem_write_d  = idex_q.mem_write;
        dest_mem_d         = dest_ex_q;
        memwb_reg_write_d  = exmem_reg_write_q;
        memwb_mem_to_reg_d = exmem_mem_to_reg_q;
        dest_wb_d          = dest_mem_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q             <= '0;
            rs_ex_q            <= '0;
            rt_ex_q            <= '0;
            dest_ex_q          <= '0;
            exmem_reg_write_q  <= 1'b0;
            exmem_mem_to_reg_q <= 1'b0;
            exmem_mem_write_q  <= 1'b0;
            dest_mem_q         <= '0;
            memwb_reg_write_q  <= 1'b0;
            memwb_mem_to_reg_q <= 1'b0;
            dest_wb_q          <= '0;
        end else begin
            idex_q             <= idex_d;
            rs_ex_q            <= rs_ex_d;
            rt_ex_q            <= rt_ex_d;
            dest_ex_q          <= dest_ex_d;
            exmem_reg_write_q  <= exmem_reg_write_d;
            exmem_mem_to_reg_q <= exmem_mem_to_reg_d;
            exmem_mem_write_q  <= exmem_mem_write_d;
            dest_mem_q         <= dest_mem_d;
            memwb_reg_write_q  <= memwb_reg_write_d;
            memwb_mem_to_reg_q <= memwb_mem_to_reg_d;
            dest_wb_q          <= dest_wb_d;
        end
    end

    assign reg_dst_ex    = idex_q.reg_dst;
    assign alu_src_ex    = idex_q.alu_src;
    assign alu_op_ex     = idex_q.alu_op;
    assign fwd_a         = FWD_EN ? fwd_sel(rs_ex_q, exmem_reg_write_q, dest_mem_q, memwb_reg_write_q, dest_wb_q) : 2'b00;
    assign fwd_b         = FWD_EN ? fwd_sel(rt_ex_q, exmem_reg_write_q, dest_mem_q, memwb_reg_write_q, dest_wb_q) : 2'b00;
    assign mem_write_mem = exmem_mem_write_q;
    assign reg_write_wb  = memwb_reg_write_q;
    assign mem_to_reg_wb = memwb_mem_to_reg_q;
    assign dest_wb       = dest_wb_q;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: instruction-level pipeline model checked every cycle on a
// forwarding (inst 0) and a non-forwarding (inst 1) instance, plus directed scenarios.
module tb_pipe_ctrl_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_s [2];
    logic        zero_s [2];
    logic [1:0]  pc_write, ifid_write, ifid_flush, pc_src_ex, jump_id, reg_dst_ex, alu_src_ex;
    logic [1:0]  mem_write_mem, reg_write_wb, mem_to_reg_wb;
    logic [2:0]  alu_op_ex [2];
    logic [1:0]  fwd_a [2];
    logic [1:0]  fwd_b [2];
    logic [4:0]  dest_wb [2];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.RA_W(5), .FWD_EN(1'b1)) u_fwd (
        .clk(clk), .reset(reset), .instr_id(instr_s[0]), .zero_ex(zero_s[0]),
        .pc_write(pc_write[0]), .ifid_write(ifid_write[0]), .ifid_flush(ifid_flush[0]),
        .pc_src_ex(pc_src_ex[0]), .jump_id(jump_id[0]), .reg_dst_ex(reg_dst_ex[0]),
        .alu_src_ex(alu_src_ex[0]), .alu_op_ex(alu_op_ex[0]), .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]),
        .mem_write_mem(mem_write_mem[0]), .reg_write_wb(reg_write_wb[0]),
        .mem_to_reg_wb(mem_to_reg_wb[0]), .dest_wb(dest_wb[0]));

    pipe_ctrl_unit #(.RA_W(5), .FWD_EN(1'b0)) u_nofwd (
        .clk(clk), .reset(reset), .instr_id(instr_s[1]), .zero_ex(zero_s[1]),
        .pc_write(pc_write[1]), .ifid_write(ifid_write[1]), .ifid_flush(ifid_flush[1]),
        .pc_src_ex(pc_src_ex[1]), .jump_id(jump_id[1]), .reg_dst_ex(reg_dst_ex[1]),
        .alu_src_ex(alu_src_ex[1]), .alu_op_ex(alu_op_ex[1]), .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]),
        .mem_write_mem(mem_write_mem[1]), .reg_write_wb(reg_write_wb[1]),
        .mem_to_reg_wb(mem_to_reg_wb[1]), .dest_wb(dest_wb[1]));

    typedef struct packed {
        logic       rw, m2r, mw, br, ne, rdst, asrc, usert, isj;
        logic [2:0] op;
        logic [4:0] rs, rt, dest;
    } dec_t;

    typedef struct {
        logic       pcw, fl, pcs, jmp, rdst, asrc, mw, rw, m2r, stall, take, isj;
        logic [2:0] op;
        logic [1:0] fa, fb;
        logic [4:0] dwb;
    } exp_t;

    // Model state: whole instruction words sitting in EX, MEM and WB (0 = bubble).
    logic [31:0] m_ex [2];
    logic [31:0] m_mem [2];
    logic [31:0] m_wb [2];
    exp_t        last [2];

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic dec_t dec(input logic [31:0] w);
        dec_t d;
        d = '0;
        d.rs = w[25:21];
        d.rt = w[20:16];
        d.dest = w[20:16];
        case (w[31:26])
            6'h00: begin
                d.usert = 1'b1;
                if (w[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a}) begin
                    d.rw = 1'b1; d.rdst = 1'b1; d.dest = w[15:11];
                    d.op = (w[5:0] == 6'h20) ? 3'b010 : (w[5:0] == 6'h22) ? 3'b110 :
                           (w[5:0] == 6'h24) ? 3'b000 : (w[5:0] == 6'h25) ? 3'b001 : 3'b111;
                end
            end
            6'h23: begin d.rw = 1; d.asrc = 1; d.m2r = 1; d.op = 3'b010; end
            6'h2b: begin d.usert = 1; d.asrc = 1; d.mw = 1; d.op = 3'b010; end
            6'h08: begin d.rw = 1; d.asrc = 1; d.op = 3'b010; end
            6'h04: begin d.usert = 1; d.br = 1; d.op = 3'b110; end
            6'h05: begin d.usert = 1; d.br = 1; d.ne = 1; d.op = 3'b110; end
            6'h02: d.isj = 1'b1;
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic reads(input dec_t d, input logic [4:0] r);
        return (r != 0) && ((r == d.rs) || (d.usert && r == d.rt));
    endfunction

    function automatic logic [1:0] fsel(input logic [4:0] s, input dec_t m, input dec_t w);
        if (s != 0 && m.rw && m.dest == s) return 2'b10;
        if (s != 0 && w.rw && w.dest == s) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t eval(input int k);
        exp_t e;
        dec_t di, dx, dm, dw;
        logic hx, hm, lu, raw;
        di = dec(instr_s[k]); dx = dec(m_ex[k]); dm = dec(m_mem[k]); dw = dec(m_wb[k]);
        hx = reads(di, dx.dest);
        hm = reads(di, dm.dest);
        lu = dx.m2r && hx;
        raw = (k == 1) && ((dx.rw && hx) || (dm.rw && hm));
        e.take = dx.br && (zero_s[k] ^ dx.ne);
        e.stall = (lu || raw) && !e.take;
        e.isj = di.isj;
        e.pcw = !e.stall;
        e.jmp = di.isj && !e.take && !e.stall;
        e.fl = e.take || e.jmp;
        e.pcs = e.take;
        e.rdst = dx.rdst; e.asrc = dx.asrc; e.op = dx.op;
        e.fa = (k == 0) ? fsel(dx.rs, dm, dw) : 2'b00;
        e.fb = (k == 0) ? fsel(dx.rt, dm, dw) : 2'b00;
        e.mw = dm.mw; e.rw = dw.rw; e.m2r = dw.m2r; e.dwb = dw.dest;
        return e;
    endfunction

    task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s[%0d] at %0t: got %0h want %0h", nm, k, $time, act, want);
        end
    endtask

    task automatic check_model(input int k);
        exp_t e;
        e = eval(k);
        last[k] = e;
        chk(k, "pc_write", pc_write[k], e.pcw);
        chk(k, "ifid_write", ifid_write[k], e.pcw);
        chk(k, "ifid_flush", ifid_flush[k], e.fl);
        chk(k, "pc_src_ex", pc_src_ex[k], e.pcs);
        chk(k, "jump_id", jump_id[k], e.jmp);
        chk(k, "reg_dst_ex", reg_dst_ex[k], e.rdst);
        chk(k, "alu_src_ex", alu_src_ex[k], e.asrc);
        chk(k, "alu_op_ex", alu_op_ex[k], e.op);
        chk(k, "fwd_a", fwd_a[k], e.fa);
        chk(k, "fwd_b", fwd_b[k], e.fb);
        chk(k, "mem_write_mem", mem_write_mem[k], e.mw);
        chk(k, "reg_write_wb", reg_write_wb[k], e.rw);
        chk(k, "mem_to_reg_wb", mem_to_reg_wb[k], e.m2r);
        chk(k, "dest_wb", dest_wb[k], e.dwb);
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            m_ex[k] = 0; m_mem[k] = 0; m_wb[k] = 0;
            last[k].stall = 0; last[k].fl = 0;
        end
    endtask

    task automatic cyc(input logic [31:0] a0, input logic z0, input logic [31:0] a1, input logic z1);
        exp_t e;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                e = eval(k);
                m_wb[k] = m_mem[k];
                m_mem[k] = m_ex[k];
                m_ex[k] = (e.stall || e.take || e.isj) ? 32'h0 : instr_s[k];
            end
        end
        #1;
        instr_s[0] = a0; zero_s[0] = z0; instr_s[1] = a1; zero_s[1] = z1;
        @(negedge clk);
        check_model(0);
        check_model(1);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < 2; k++) begin
            chk(k, "rst_pc_write", pc_write[k], 1);
            chk(k, "rst_ifid_write", ifid_write[k], 1);
            chk(k, "rst_mem_write_mem", mem_write_mem[k], 0);
            chk(k, "rst_reg_write_wb", reg_write_wb[k], 0);
            chk(k, "rst_alu_op_ex", alu_op_ex[k], 0);
            chk(k, "rst_dest_wb", dest_wb[k], 0);
        end
    endtask

    function automatic logic [31:0] rnd_instr();
        int a, b, c;
        logic [5:0] fns [5];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
        a = $urandom_range(0, 4); b = $urandom_range(0, 4); c = $urandom_range(0, 4);
        case ($urandom_range(0, 10))
            0, 1: return itype(6'h23, a, b, $urandom_range(0, 60));
            2:    return itype(6'h2b, a, b, $urandom_range(0, 60));
            3:    return itype(6'h08, a, b, $urandom_range(0, 60));
            4:    return itype(6'h04, a, b, 4);
            5:    return itype(6'h05, a, b, 4);
            6:    return {6'h02, 26'($urandom)};
            7, 8: return rtype(a, b, c, fns[$urandom_range(0, 4)]);
            9:    return rtype(a, b, c, 6'h21);
            default: return itype(6'h3f, a, b, 0);
        endcase
    endfunction

    initial begin
        logic [31:0] lw2, add3, add_s, sub_s, bne_s, addi_s, j_s, or_s, sw_s;
        logic [31:0] nxt [2];
        logic        zn [2];
        instr_s[0] = 0; instr_s[1] = 0; zero_s[0] = 0; zero_s[1] = 0;
        clear_model();
        #3;
        check_reset_outputs();
        @(negedge clk);
        reset = 1'b0;

        // Load-use: one stall, bubble in EX, then WB forwarding.
        lw2  = itype(6'h23, 1, 2, 0);
        add3 = rtype(2, 4, 3, 6'h20);
        cyc(lw2, 0, 0, 0);
        cyc(add3, 0, 0, 0);
        chk(0, "lu_pc_write", pc_write[0], 0);
        chk(0, "lu_ifid_write", ifid_write[0], 0);
        cyc(add3, 0, 0, 0);
        chk(0, "lu_bubble_alu_src", alu_src_ex[0], 0);
        chk(0, "lu_resume", pc_write[0], 1);
        cyc(0, 0, 0, 0);
        chk(0, "lu_fwd_a", fwd_a[0], 2'b01);
        chk(0, "lu_fwd_b", fwd_b[0], 2'b00);
        chk(0, "lu_add_op", alu_op_ex[0], 3'b010);
        drain();

        // EX/MEM forwarding on both operands; $0 destination never forwards.
        add_s = rtype(1, 2, 3, 6'h20);
        sub_s = rtype(3, 3, 5, 6'h22);
        cyc(add_s, 0, 0, 0); cyc(sub_s, 0, 0, 0); cyc(0, 0, 0, 0);
        chk(0, "mem_fwd_a", fwd_a[0], 2'b10);
        chk(0, "mem_fwd_b", fwd_b[0], 2'b10);
        cyc(rtype(1, 2, 0, 6'h20), 0, 0, 0); cyc(rtype(0, 0, 5, 6'h22), 0, 0, 0); cyc(0, 0, 0, 0);
        chk(0, "zero_fwd_a", fwd_a[0], 2'b00);
        drain();

        // Taken bne flushes and bubbles the younger addi; not-taken lets it through.
        bne_s  = itype(6'h05, 1, 2, 3);
        addi_s = itype(6'h08, 1, 7, 5);
        cyc(bne_s, 0, 0, 0); cyc(addi_s, 0, 0, 0);
        chk(0, "bne_pc_src", pc_src_ex[0], 1);
        chk(0, "bne_flush", ifid_flush[0], 1);
        cyc(0, 0, 0, 0);
        chk(0, "bne_bubble_alu_src", alu_src_ex[0], 0);
        cyc(bne_s, 0, 0, 0); cyc(addi_s, 1, 0, 0);
        chk(0, "bne_nt_pc_src", pc_src_ex[0], 0);
        chk(0, "bne_nt_flush", ifid_flush[0], 0);
        cyc(0, 0, 0, 0);
        chk(0, "bne_nt_alu_src", alu_src_ex[0], 1);
        drain();

        // Jump in ID, and jump squashed by a taken branch ahead of it.
        j_s = {6'h02, 26'd100};
        cyc(j_s, 0, 0, 0);
        chk(0, "j_jump_id", jump_id[0], 1);
        chk(0, "j_flush", ifid_flush[0], 1);
        cyc(bne_s, 0, 0, 0); cyc(j_s, 0, 0, 0);
        chk(0, "j_squash_jump_id", jump_id[0], 0);
        chk(0, "j_squash_pc_src", pc_src_ex[0], 1);
        drain();

        // No forwarding: RAW on the previous result stalls twice.
        or_s = rtype(3, 1, 4, 6'h25);
        cyc(0, 0, add_s, 0);
        cyc(0, 0, or_s, 0);
        chk(1, "raw_stall1", pc_write[1], 0);
        cyc(0, 0, or_s, 0);
        chk(1, "raw_stall2", pc_write[1], 0);
        cyc(0, 0, or_s, 0);
        chk(1, "raw_resume", pc_write[1], 1);
        cyc(0, 0, 0, 0);
        chk(1, "raw_fwd_a", fwd_a[1], 2'b00);
        chk(1, "raw_or_op", alu_op_ex[1], 3'b001);
        drain();

        // Asynchronous reset with a store in MEM and a load in WB.
        sw_s = itype(6'h2b, 1, 5, 4);
        cyc(lw2, 0, 0, 0); cyc(sw_s, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        chk(0, "pre_rst_mem_write", mem_write_mem[0], 1);
        chk(0, "pre_rst_reg_write", reg_write_wb[0], 1);
        #2 reset = 1'b1;
        #1 check_reset_outputs();
        clear_model();
        @(negedge clk);
        reset = 1'b0;
        drain();

        // Random streams on both instances, honouring the stall/flush the model predicts.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (last[k].stall) nxt[k] = instr_s[k];
                else if (last[k].fl) nxt[k] = 32'h0;
                else nxt[k] = rnd_instr();
                zn[k] = 1'($urandom_range(0, 1));
            end
            cyc(nxt[0], zn[0], nxt[1], zn[1]);
            if (i == 1500) begin
                #2 reset = 1'b1;
                #1 check_reset_outputs();
                clear_model();
                @(negedge clk);
                reset = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
